// File: rtl/ifu_pkg.sv
// Shared width, state encoding, PC increment and buffer entry layout for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } ifu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            fault;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer: pushed entry visible at head the next cycle; flush beats push/pop.
// Pop on empty is ignored; the caller reserves a slot before every push, so it never overflows.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  ifu_entry_t                   push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output ifu_entry_t                   head,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ifu_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: one outstanding imem request, returned words buffered with their PC for decode; stops requesting when no buffer slot is free.
// IFU_MISALIGN_TRAP_EN: a misaligned redirect yields one fault entry and halts fetch until the next redirect; otherwise redirect_pc[1:0] is ignored.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_t      state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_valid_q;
  logic            drop_q;
  logic            req_fire;
  logic            slot_free;
  logic            fetch_en;
  logic            rsp_push;
  logic            fault_push;
  logic            push;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  ifu_entry_t      push_entry;
  ifu_entry_t      head;

`ifdef IFU_MISALIGN_TRAP_EN
  logic halt_q;
  logic fault_pend_q;
  logic misaligned;

  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
  assign fetch_en     = slot_free && !halt_q;
  assign fault_push   = (state_q == IDLE) && fault_pend_q && slot_free && !redirect_valid;
`else
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign fetch_en     = slot_free;
  assign fault_push   = 1'b0;
`endif

  assign slot_free = (count < CW'(FIFO_DEPTH));
  assign req_fire  = req_valid_q && imem_req_ready;
  // A redirect in the response cycle makes that word stale, so it is never buffered.
  assign rsp_push  = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  assign push      = rsp_push || fault_push;

  always_comb begin
    push_entry = '{pc: req_addr_q, data: imem_rsp_data, fault: 1'b0};
    if (fault_push) begin
      push_entry = '{pc: pc_q, data: '0, fault: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      drop_q      <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      halt_q       <= 1'b0;
      fault_pend_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!redirect_valid && fetch_en) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_q;
          end
        end
        REQ: begin
          // A request already presented must be held until accepted; its data is then dropped.
          if (req_fire) begin
            req_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            state_q     <= (drop_q || redirect_valid) ? DROP : WAIT;
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_q <= IDLE;
          end else if (redirect_valid) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (redirect_valid) begin
        pc_q <= redirect_tgt;
      end else if (req_fire && !drop_q) begin
        pc_q <= pc_q + PC_STEP;
      end

`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_valid) begin
        halt_q       <= misaligned;
        fault_pend_q <= misaligned;
      end else if (fault_push) begin
        fault_pend_q <= 1'b0;
      end
`endif
    end
  end

  ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (instr_ready && !redirect_valid),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = !fifo_empty;
  assign instr_data     = head.data;
  assign instr_pc       = head.pc;
  assign instr_fault    = head.fault && !fifo_empty;

endmodule
